// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: merges a buffered ALU write stream and an
// unbuffered, higher-priority load write stream onto one registered write
// port, and publishes a per-register pending bitmap for issue-stage stalls.
module regfile_writeback_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_alu_valid,
  output logic                           o_alu_ready,
  input  logic [ADDR_W-1:0]              i_alu_rd,
  input  logic [XLEN-1:0]                i_alu_data,
  input  logic                           i_mem_valid,
  output logic                           o_mem_ready,
  input  logic [ADDR_W-1:0]              i_mem_rd,
  input  logic [XLEN-1:0]                i_mem_data,
  output logic                           o_rf_we,
  output logic [ADDR_W-1:0]              o_rf_wa,
  output logic [XLEN-1:0]                o_rf_wd,
  output logic [(2**ADDR_W)-1:0]         o_pending,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // ALU write buffer; a per-slot valid bit keeps the pending scan simple
  logic [ADDR_W-1:0] r_fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_wa;
  logic [XLEN-1:0]   r_rf_wd;

  logic              w_ready;
  logic              w_push;
  logic              w_mem_wr;
  logic              w_pop;
  logic [NREG-1:0]   w_pending;

  // Handshake decode: readiness depends only on registered occupancy
  always_comb begin
    w_ready  = (r_count < DEPTH_C);
    w_push   = i_alu_valid && w_ready && (i_alu_rd != {ADDR_W{1'b0}});
    w_mem_wr = i_mem_valid && w_ready && (i_mem_rd != {ADDR_W{1'b0}});
    // A load to x0 is a bubble, so the buffer may drain under it
    w_pop    = !w_mem_wr && (r_count != {CNT_W{1'b0}});
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_rd[i]   <= {ADDR_W{1'b0}};
        r_fifo_data[i] <= {XLEN{1'b0}};
      end
      r_fifo_vld <= {FIFO_DEPTH{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo_rd[r_wr_ptr]   <= i_alu_rd;
        r_fifo_data[r_wr_ptr] <= i_alu_data;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Slot valid bits: clear the head on pop, set the tail on push
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_fifo_vld[i] <= 1'b1;
        end else if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
          r_fifo_vld[i] <= 1'b0;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port: load first, then FIFO head, else idle holding addr/data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= {ADDR_W{1'b0}};
      r_rf_wd <= {XLEN{1'b0}};
    end else if (w_mem_wr) begin
      r_rf_we <= 1'b1;
      r_rf_wa <= i_mem_rd;
      r_rf_wd <= i_mem_data;
    end else if (w_pop) begin
      r_rf_we <= 1'b1;
      r_rf_wa <= r_fifo_rd[r_rd_ptr];
      r_rf_wd <= r_fifo_data[r_rd_ptr];
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  // Pending bitmap from queued entries plus the write currently on the port
  always_comb begin
    w_pending = {NREG{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_pending[r_fifo_rd[i]] = w_pending[r_fifo_rd[i]] | r_fifo_vld[i];
    end
    w_pending[r_rf_wa] = w_pending[r_rf_wa] | r_rf_we;
    w_pending[0]       = 1'b0;
  end

  assign o_alu_ready  = w_ready;
  assign o_mem_ready  = w_ready;
  assign o_rf_we      = r_rf_we;
  assign o_rf_wa      = r_rf_wa;
  assign o_rf_wd      = r_rf_wd;
  assign o_pending    = w_pending;
  assign o_fifo_count = r_count;

  regfile_writeback_arbiter_chk #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_count (r_count)
  );

endmodule

// Simulation-only guard for illegal buffer operations
module regfile_writeback_arbiter_chk #(
  parameter int CNT_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  input logic             i_push,
  input logic             i_pop,
  input logic [CNT_W-1:0] i_count
);

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && (i_count == CNT_W'(FIFO_DEPTH))));

  a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_pop && (i_count == {CNT_W{1'b0}})));

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expectations.
module tb_regfile_writeback_arbiter;

  localparam int ADDR_W = 5;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic [31:0]       pending;
  logic [2:0]        fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback_arbiter #(
    .ADDR_W     (ADDR_W),
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (alu_valid),
    .o_alu_ready  (alu_ready),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_mem_valid  (mem_valid),
    .o_mem_ready  (mem_ready),
    .i_mem_rd     (mem_rd),
    .i_mem_data   (mem_data),
    .o_rf_we      (rf_we),
    .o_rf_wa      (rf_wa),
    .o_rf_wd      (rf_wd),
    .o_pending    (pending),
    .o_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_wa", 64'(rf_wa), 64'd0);
    check("rst_wd", 64'(rf_wd), 64'd0);
    check("rst_cnt", 64'(fifo_count), 64'd0);
    check("rst_pend", 64'(pending), 64'd0);
    rst = 1'b0;
    check("rdy_alu_after_rst", 64'(alu_ready), 64'd1);
    check("rdy_mem_after_rst", 64'(mem_ready), 64'd1);

    // 1: single load write
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    check("t1_we", 64'(rf_we), 64'd1);
    check("t1_wa", 64'(rf_wa), 64'd5);
    check("t1_wd", 64'(rf_wd), 64'hDEADBEEF);
    check("t1_pend", 64'(pending), 64'h20);
    step();
    check("t1_we_off", 64'(rf_we), 64'd0);
    check("t1_pend_off", 64'(pending), 64'd0);
    check("t1_wd_hold", 64'(rf_wd), 64'hDEADBEEF);

    // 2: single ALU write, two-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    step();
    idle_inputs();
    check("t2_cnt1", 64'(fifo_count), 64'd1);
    check("t2_pend", 64'(pending), 64'h8);
    check("t2_we_early", 64'(rf_we), 64'd0);
    step();
    check("t2_we", 64'(rf_we), 64'd1);
    check("t2_wa", 64'(rf_wa), 64'd3);
    check("t2_wd", 64'(rf_wd), 64'h11);
    check("t2_cnt0", 64'(fifo_count), 64'd0);
    step();
    check("t2_we_off", 64'(rf_we), 64'd0);

    // 3: simultaneous ALU and load, load wins
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB;
    step();
    idle_inputs();
    check("t3_wa_mem", 64'(rf_wa), 64'd2);
    check("t3_wd_mem", 64'(rf_wd), 64'hB);
    check("t3_cnt", 64'(fifo_count), 64'd1);
    check("t3_pend", 64'(pending), 64'h6);
    step();
    check("t3_we_alu", 64'(rf_we), 64'd1);
    check("t3_wa_alu", 64'(rf_wa), 64'd1);
    check("t3_wd_alu", 64'(rf_wd), 64'hA);
    check("t3_pend2", 64'(pending), 64'h2);
    step();

    // 4: loads every cycle starve the FIFO until it fills
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'h100 + 32'(k);
      mem_valid = 1'b1; mem_rd = 5'(16 + k); mem_data = 32'h200 + 32'(k);
      step();
      check("t4_mem_wa", 64'(rf_wa), 64'(16 + k));
      check("t4_mem_wd", 64'(rf_wd), 64'(32'h200 + 32'(k)));
    end
    alu_valid = 1'b0;
    mem_rd = 5'd20; mem_data = 32'h300;
    check("t4_cnt_full", 64'(fifo_count), 64'd4);
    check("t4_alu_stall", 64'(alu_ready), 64'd0);
    check("t4_mem_stall", 64'(mem_ready), 64'd0);
    check("t4_pend_full", 64'(pending), 64'h0008_001E);
    step();
    check("t4_pop1_wa", 64'(rf_wa), 64'd1);
    check("t4_pop1_wd", 64'(rf_wd), 64'h100);
    check("t4_cnt3", 64'(fifo_count), 64'd3);
    check("t4_mem_rdy_back", 64'(mem_ready), 64'd1);
    idle_inputs();
    for (int k = 1; k < 4; k++) begin
      step();
      check("t4_pop_we", 64'(rf_we), 64'd1);
      check("t4_pop_wa", 64'(rf_wa), 64'(k + 1));
      check("t4_pop_wd", 64'(rf_wd), 64'(32'h100 + 32'(k)));
    end
    check("t4_cnt_empty", 64'(fifo_count), 64'd0);
    step();
    check("t4_we_off", 64'(rf_we), 64'd0);

    // 5: writes to x0 are accepted and dropped; load to x0 lets FIFO drain
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
    check("t5_alu_rdy", 64'(alu_ready), 64'd1);
    check("t5_mem_rdy", 64'(mem_ready), 64'd1);
    step();
    idle_inputs();
    check("t5_x0_we", 64'(rf_we), 64'd0);
    check("t5_x0_cnt", 64'(fifo_count), 64'd0);
    check("t5_x0_pend", 64'(pending), 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    idle_inputs();
    check("t5_cnt1", 64'(fifo_count), 64'd1);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h99;
    step();
    idle_inputs();
    check("t5_bubble_we", 64'(rf_we), 64'd1);
    check("t5_bubble_wa", 64'(rf_wa), 64'd7);
    check("t5_bubble_wd", 64'(rf_wd), 64'h77);
    check("t5_pend", 64'(pending), 64'h80);
    step();
    check("t5_we_off", 64'(rf_we), 64'd0);

    // 6: asynchronous reset discards queued writes
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(8 + k); alu_data = 32'h400 + 32'(k);
      mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h500;
      step();
    end
    idle_inputs();
    check("t6_cnt3", 64'(fifo_count), 64'd3);
    check("t6_we_pre", 64'(rf_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_we", 64'(rf_we), 64'd0);
    check("t6_rst_cnt", 64'(fifo_count), 64'd0);
    check("t6_rst_pend", 64'(pending), 64'd0);
    check("t6_rst_wa", 64'(rf_wa), 64'd0);
    step();
    rst = 1'b0;
    check("t6_alu_rdy", 64'(alu_ready), 64'd1);
    check("t6_mem_rdy", 64'(mem_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_no_stale_we", 64'(rf_we), 64'd0);
    end
    check("t6_cnt_end", 64'(fifo_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
